// File: rtl/core_mem_stage.sv
`default_nettype none
// ============================================================================
// core_mem_stage
// RV32IM memory stage: issues load/store on a req/gnt/rvalid port, aligns
// load data and registers the writeback-stage outputs.
// Revision: 1.0
// ============================================================================
module core_mem_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            ex_valid_i,
  output logic            ex_ready_o,
  input  logic [6:0]      ex_opcode_i,
  input  logic [2:0]      ex_funct3_i,
  input  logic [4:0]      ex_rd_i,
  input  logic            ex_reg_write_i,
  input  logic            ex_is_muldiv_i,
  input  logic [XLEN-1:0] ex_alu_result_i,
  input  logic [XLEN-1:0] ex_mul_result_i,
  input  logic [XLEN-1:0] ex_store_data_i,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [3:0]      dmem_be_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  input  logic            dmem_gnt_i,
  input  logic            dmem_rvalid_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic            wb_valid_o,
  output logic [4:0]      wb_rd_o,
  output logic            wb_reg_write_o,
  output logic [XLEN-1:0] wb_rd_din_o,
  output logic            wb_misalign_o
);

  localparam logic [6:0] C_OP_LOAD  = 7'b0000011;
  localparam logic [6:0] C_OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_ex_ready;
  logic            r_dmem_req;
  logic            r_dmem_we;
  logic [XLEN-1:0] r_dmem_addr;
  logic [3:0]      r_dmem_be;
  logic [XLEN-1:0] r_dmem_wdata;
  logic            r_is_load;
  logic            r_reg_write;
  logic [2:0]      r_funct3;
  logic [1:0]      r_addr_lo;
  logic [4:0]      r_rd;
  logic            r_wb_valid;
  logic            r_wb_reg_write;
  logic            r_wb_misalign;
  logic [4:0]      r_wb_rd;
  logic [XLEN-1:0] r_wb_rd_din;

  logic            w_accept;
  logic            w_is_load;
  logic            w_is_mem;
  logic            w_misalign;
  logic [1:0]      w_addr_lo;
  logic [3:0]      w_be;
  logic [XLEN-1:0] w_wdata;
  logic [XLEN-1:0] w_exec_result;
  logic [7:0]      w_ld_byte;
  logic [15:0]     w_ld_half;
  logic [XLEN-1:0] w_load_data;

  assign w_accept      = ex_valid_i && r_ex_ready;
  assign w_is_load     = (ex_opcode_i == C_OP_LOAD);
  assign w_is_mem      = w_is_load || (ex_opcode_i == C_OP_STORE);
  assign w_addr_lo     = ex_alu_result_i[1:0];
  assign w_exec_result = ex_is_muldiv_i ? ex_mul_result_i : ex_alu_result_i;

  // Reserved size encodings are reported the same way as a misaligned access.
  always_comb begin
    w_misalign = 1'b0;
    case (ex_funct3_i)
      3'b011, 3'b110, 3'b111: w_misalign = 1'b1;
      default: begin
        case (ex_funct3_i[1:0])
          2'b01:   w_misalign = w_addr_lo[0];
          2'b10:   w_misalign = |w_addr_lo;
          default: w_misalign = 1'b0;
        endcase
      end
    endcase
  end

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = ex_store_data_i;
    case (ex_funct3_i[1:0])
      2'b00: begin
        w_be    = 4'b0001 << w_addr_lo;
        w_wdata = {4{ex_store_data_i[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << {w_addr_lo[1], 1'b0};
        w_wdata = {2{ex_store_data_i[15:0]}};
      end
      default: ;
    endcase
    if (w_is_load) begin
      w_wdata = '0;
    end
  end

  assign w_ld_byte = 8'(dmem_rdata_i >> {r_addr_lo, 3'b000});
  assign w_ld_half = 16'(dmem_rdata_i >> {r_addr_lo[1], 4'b0000});

  always_comb begin
    w_load_data = dmem_rdata_i;
    case (r_funct3)
      3'b000:  w_load_data = {{(XLEN-8){w_ld_byte[7]}}, w_ld_byte};
      3'b001:  w_load_data = {{(XLEN-16){w_ld_half[15]}}, w_ld_half};
      3'b100:  w_load_data = {{(XLEN-8){1'b0}}, w_ld_byte};
      3'b101:  w_load_data = {{(XLEN-16){1'b0}}, w_ld_half};
      default: w_load_data = dmem_rdata_i;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state        <= S_IDLE;
      r_ex_ready     <= 1'b0;
      r_dmem_req     <= 1'b0;
      r_dmem_we      <= 1'b0;
      r_dmem_addr    <= '0;
      r_dmem_be      <= 4'b0000;
      r_dmem_wdata   <= '0;
      r_is_load      <= 1'b0;
      r_reg_write    <= 1'b0;
      r_funct3       <= 3'b000;
      r_addr_lo      <= 2'b00;
      r_rd           <= 5'd0;
      r_wb_valid     <= 1'b0;
      r_wb_reg_write <= 1'b0;
      r_wb_misalign  <= 1'b0;
      r_wb_rd        <= 5'd0;
      r_wb_rd_din    <= '0;
    end else begin
      r_wb_valid    <= 1'b0;
      r_wb_misalign <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_ex_ready <= 1'b1;
          if (w_accept) begin
            r_is_load   <= w_is_load;
            r_reg_write <= ex_reg_write_i;
            r_funct3    <= ex_funct3_i;
            r_addr_lo   <= w_addr_lo;
            r_rd        <= ex_rd_i;
            if (!w_is_mem) begin
              r_wb_valid     <= 1'b1;
              r_wb_rd        <= ex_rd_i;
              r_wb_reg_write <= ex_reg_write_i && (ex_rd_i != 5'd0);
              r_wb_rd_din    <= w_exec_result;
            end else if (w_misalign) begin
              r_wb_valid     <= 1'b1;
              r_wb_misalign  <= 1'b1;
              r_wb_rd        <= ex_rd_i;
              r_wb_reg_write <= 1'b0;
            end else begin
              r_state      <= S_REQ;
              r_ex_ready   <= 1'b0;
              r_dmem_req   <= 1'b1;
              r_dmem_we    <= !w_is_load;
              r_dmem_addr  <= {ex_alu_result_i[XLEN-1:2], 2'b00};
              r_dmem_be    <= w_be;
              r_dmem_wdata <= w_wdata;
            end
          end
        end
        S_REQ: begin
          if (dmem_gnt_i) begin
            r_dmem_req <= 1'b0;
            if (r_is_load) begin
              r_state <= S_RESP;
            end else begin
              r_state        <= S_IDLE;
              r_ex_ready     <= 1'b1;
              r_wb_valid     <= 1'b1;
              r_wb_rd        <= r_rd;
              r_wb_reg_write <= 1'b0;
            end
          end
        end
        S_RESP: begin
          if (dmem_rvalid_i) begin
            r_state        <= S_IDLE;
            r_ex_ready     <= 1'b1;
            r_wb_valid     <= 1'b1;
            r_wb_rd        <= r_rd;
            r_wb_reg_write <= r_reg_write && (r_rd != 5'd0);
            r_wb_rd_din    <= w_load_data;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_dmem_req <= 1'b0;
        end
      endcase
    end
  end

  assign ex_ready_o     = r_ex_ready;
  assign dmem_req_o     = r_dmem_req;
  assign dmem_we_o      = r_dmem_we;
  assign dmem_addr_o    = r_dmem_addr;
  assign dmem_be_o      = r_dmem_be;
  assign dmem_wdata_o   = r_dmem_wdata;
  assign wb_valid_o     = r_wb_valid;
  assign wb_rd_o        = r_wb_rd;
  assign wb_reg_write_o = r_wb_reg_write;
  assign wb_rd_din_o    = r_wb_rd_din;
  assign wb_misalign_o  = r_wb_misalign;

endmodule
`default_nettype wire

// File: tb/tb_core_mem_stage.sv
`default_nettype none
// ============================================================================
// tb_core_mem_stage
// Directed and randomized self-checking bench for core_mem_stage.
// Revision: 1.0
// ============================================================================
module tb_core_mem_stage;

  localparam logic [6:0] C_LOAD  = 7'b0000011;
  localparam logic [6:0] C_STORE = 7'b0100011;
  localparam logic [6:0] C_ALU   = 7'b0110011;
  localparam logic [6:0] C_ALUI  = 7'b0010011;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        ex_valid_i;
  logic        ex_ready_o;
  logic [6:0]  ex_opcode_i;
  logic [2:0]  ex_funct3_i;
  logic [4:0]  ex_rd_i;
  logic        ex_reg_write_i;
  logic        ex_is_muldiv_i;
  logic [31:0] ex_alu_result_i;
  logic [31:0] ex_mul_result_i;
  logic [31:0] ex_store_data_i;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_o;
  logic        wb_reg_write_o;
  logic [31:0] wb_rd_din_o;
  logic        wb_misalign_o;

  core_mem_stage #(.XLEN(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
    .ex_opcode_i(ex_opcode_i), .ex_funct3_i(ex_funct3_i), .ex_rd_i(ex_rd_i),
    .ex_reg_write_i(ex_reg_write_i), .ex_is_muldiv_i(ex_is_muldiv_i),
    .ex_alu_result_i(ex_alu_result_i), .ex_mul_result_i(ex_mul_result_i),
    .ex_store_data_i(ex_store_data_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i),
    .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_reg_write_o(wb_reg_write_o),
    .wb_rd_din_o(wb_rd_din_o), .wb_misalign_o(wb_misalign_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        misalign;
    logic        rw;
    logic        chk_rd;
    logic [4:0]  rd;
    logic        chk_din;
    logic [31:0] din;
  } wb_exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic [4:0]  rd;
    logic        rw;
  } req_exp_t;

  wb_exp_t  wb_q[$];
  req_exp_t req_q[$];
  int       checks   = 0;
  int       failures = 0;
  bit       auto_mem = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Access size in bytes from the low two funct3 bits.
  function automatic int unsigned acc_bytes(input logic [2:0] f3);
    return 32'd1 << f3[1:0];
  endfunction

  function automatic bit is_misaligned(input logic [2:0] f3, input logic [31:0] addr);
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
    return (addr % acc_bytes(f3)) != 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
    int unsigned mask;
    mask = ((32'd1 << acc_bytes(f3)) - 1) << (addr % 4);
    return mask[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] data);
    logic [31:0] w;
    int unsigned n;
    n = acc_bytes(f3);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = data[8*(i % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] lo,
                                             input logic [31:0] rdata);
    int unsigned n;
    longint      v;
    n = acc_bytes(f3);
    v = 0;
    for (int i = 0; i < n; i++) v += longint'(rdata[8*(int'(lo) + i) +: 8]) << (8 * i);
    if (!f3[2] && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
    return v[31:0];
  endfunction

  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                       input logic rw, input logic md, input logic [31:0] alu,
                       input logic [31:0] mul, input logic [31:0] sd);
    int guard;
    guard = 0;
    @(negedge clk_i);
    while (!ex_ready_o && guard < 50) begin
      @(negedge clk_i);
      guard++;
    end
    if (!ex_ready_o) begin
      check("ready_timeout", {31'd0, ex_ready_o}, 32'd1);
      return;
    end
    if (op == C_LOAD || op == C_STORE) begin
      if (is_misaligned(f3, alu)) begin
        wb_q.push_back('{1'b1, 1'b0, 1'b0, rd, 1'b0, 32'd0});
      end else begin
        req_q.push_back('{op == C_STORE, alu & ~32'd3, model_be(f3, alu),
                          (op == C_STORE) ? model_wdata(f3, sd) : 32'd0,
                          f3, alu[1:0], rd, rw});
        if (op == C_STORE) wb_q.push_back('{1'b0, 1'b0, 1'b0, rd, 1'b0, 32'd0});
      end
    end else begin
      wb_q.push_back('{1'b0, rw && (rd != 5'd0), 1'b1, rd, 1'b1, md ? mul : alu});
    end
    ex_opcode_i     = op;
    ex_funct3_i     = f3;
    ex_rd_i         = rd;
    ex_reg_write_i  = rw;
    ex_is_muldiv_i  = md;
    ex_alu_result_i = alu;
    ex_mul_result_i = mul;
    ex_store_data_i = sd;
    ex_valid_i      = 1'b1;
    @(posedge clk_i);
    #1;
    ex_valid_i = 1'b0;
  endtask

  // Memory responder used in randomized mode: random grant and response delays,
  // stray rvalids whenever no load is waiting for data.
  initial begin : responder
    bit       pend;
    int       cnt;
    req_exp_t cur;
    pend = 1'b0;
    cnt  = 0;
    forever begin
      @(negedge clk_i);
      if (auto_mem) begin
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b0;
        if (pend) begin
          if (cnt == 0) begin
            dmem_rvalid_i = 1'b1;
            dmem_rdata_i  = $urandom;
            wb_q.push_back('{1'b0, cur.rw && (cur.rd != 5'd0), 1'b1, cur.rd, 1'b1,
                             model_load(cur.f3, cur.lo, dmem_rdata_i)});
            pend = 1'b0;
          end else begin
            cnt--;
          end
        end else begin
          if (dmem_req_o) begin
            if (req_q.size() == 0) begin
              check("req_unexpected", {31'd0, dmem_req_o}, 32'd0);
            end else begin
              check("req_addr", dmem_addr_o, req_q[0].addr);
              check("req_be", {28'd0, dmem_be_o}, {28'd0, req_q[0].be});
              check("req_we", {31'd0, dmem_we_o}, {31'd0, req_q[0].we});
              check("req_wdata", dmem_wdata_o, req_q[0].wdata);
              if ($urandom_range(0, 2) != 0) begin
                dmem_gnt_i = 1'b1;
                cur = req_q.pop_front();
                if (!cur.we) begin
                  pend = 1'b1;
                  cnt  = $urandom_range(0, 2);
                end
              end
            end
          end
          if (!pend && $urandom_range(0, 7) == 0) begin
            dmem_rvalid_i = 1'b1;
            dmem_rdata_i  = $urandom;
          end
        end
      end else begin
        pend = 1'b0;
      end
    end
  end

  // Writeback compare: every wb_valid_o pulse must match the next expected result.
  initial begin : wb_compare
    wb_exp_t e;
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        if (wb_valid_o) begin
          if (wb_q.size() == 0) begin
            check("wb_valid_unexpected", {31'd0, wb_valid_o}, 32'd0);
          end else begin
            e = wb_q.pop_front();
            check("wb_misalign", {31'd0, wb_misalign_o}, {31'd0, e.misalign});
            check("wb_reg_write", {31'd0, wb_reg_write_o}, {31'd0, e.rw});
            if (e.chk_rd) check("wb_rd", {27'd0, wb_rd_o}, {27'd0, e.rd});
            if (e.chk_din) check("wb_rd_din", wb_rd_din_o, e.din);
          end
        end else begin
          check("wb_misalign_idle", {31'd0, wb_misalign_o}, 32'd0);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [2:0] st_f3[6];
    logic [6:0] op;
    logic [2:0] f3;
    logic [31:0] addr;
    logic [4:0] rd;
    int guard;
    st_f3 = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};

    rst_i = 1'b1;
    ex_valid_i = 1'b0; ex_opcode_i = '0; ex_funct3_i = '0; ex_rd_i = '0;
    ex_reg_write_i = 1'b0; ex_is_muldiv_i = 1'b0; ex_alu_result_i = '0;
    ex_mul_result_i = '0; ex_store_data_i = '0;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
    repeat (2) @(negedge clk_i);
    check("rst_ex_ready", {31'd0, ex_ready_o}, 32'd0);
    check("rst_req", {31'd0, dmem_req_o}, 32'd0);
    check("rst_wb_valid", {31'd0, wb_valid_o}, 32'd0);
    check("rst_wb_din", wb_rd_din_o, 32'd0);
    check("rst_wb_rd", {27'd0, wb_rd_o}, 32'd0);
    rst_i = 1'b0;

    // ALU and mul results
    issue(C_ALU, 3'd0, 5'd5, 1'b1, 1'b0, 32'h1234, 32'h0, 32'h0);
    @(negedge clk_i);
    check("alu_valid", {31'd0, wb_valid_o}, 32'd1);
    check("alu_rd", {27'd0, wb_rd_o}, 32'd5);
    check("alu_din", wb_rd_din_o, 32'h1234);
    check("alu_rw", {31'd0, wb_reg_write_o}, 32'd1);
    issue(C_ALU, 3'd0, 5'd5, 1'b1, 1'b1, 32'h1111, 32'hDEAD, 32'h0);
    @(negedge clk_i);
    check("mul_valid", {31'd0, wb_valid_o}, 32'd1);
    check("mul_din", wb_rd_din_o, 32'hDEAD);

    // LB 0x103, grant after two request cycles
    wb_q.push_back('{1'b0, 1'b1, 1'b1, 5'd7, 1'b1, 32'hFFFF_FF80});
    issue(C_LOAD, 3'b000, 5'd7, 1'b1, 1'b0, 32'h103, 32'h0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      check("lb_req", {31'd0, dmem_req_o}, 32'd1);
      check("lb_addr", dmem_addr_o, 32'h100);
      check("lb_be", {28'd0, dmem_be_o}, 32'h8);
      check("lb_we", {31'd0, dmem_we_o}, 32'd0);
      check("lb_ex_ready", {31'd0, ex_ready_o}, 32'd0);
      if (i == 1) dmem_gnt_i = 1'b1;
    end
    @(negedge clk_i);
    dmem_gnt_i = 1'b0;
    check("lb_resp_req", {31'd0, dmem_req_o}, 32'd0);
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'h80FF_0000;
    @(negedge clk_i);
    dmem_rvalid_i = 1'b0;
    check("lb_valid", {31'd0, wb_valid_o}, 32'd1);
    check("lb_din", wb_rd_din_o, 32'hFFFF_FF80);

    // LBU 0x103, immediate grant
    wb_q.push_back('{1'b0, 1'b1, 1'b1, 5'd7, 1'b1, 32'h0000_0080});
    issue(C_LOAD, 3'b100, 5'd7, 1'b1, 1'b0, 32'h103, 32'h0, 32'h0);
    @(negedge clk_i);
    dmem_gnt_i = 1'b1;
    @(negedge clk_i);
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'h80FF_0000;
    @(negedge clk_i);
    dmem_rvalid_i = 1'b0;
    check("lbu_din", wb_rd_din_o, 32'h0000_0080);

    // SH 0x202
    issue(C_STORE, 3'b001, 5'd3, 1'b1, 1'b0, 32'h202, 32'h0, 32'hAAAA_BEEF);
    @(negedge clk_i);
    check("sh_be", {28'd0, dmem_be_o}, 32'hC);
    check("sh_wdata", dmem_wdata_o, 32'hBEEF_BEEF);
    check("sh_we", {31'd0, dmem_we_o}, 32'd1);
    dmem_gnt_i = 1'b1;
    @(negedge clk_i);
    dmem_gnt_i = 1'b0;
    check("sh_valid", {31'd0, wb_valid_o}, 32'd1);
    check("sh_rw", {31'd0, wb_reg_write_o}, 32'd0);

    // Misaligned LW
    issue(C_LOAD, 3'b010, 5'd9, 1'b1, 1'b0, 32'h101, 32'h0, 32'h0);
    @(negedge clk_i);
    check("mis_req", {31'd0, dmem_req_o}, 32'd0);
    check("mis_valid", {31'd0, wb_valid_o}, 32'd1);
    check("mis_flag", {31'd0, wb_misalign_o}, 32'd1);
    check("mis_rw", {31'd0, wb_reg_write_o}, 32'd0);

    // Load to x0
    wb_q.push_back('{1'b0, 1'b0, 1'b1, 5'd0, 1'b1, 32'h1234_5678});
    issue(C_LOAD, 3'b010, 5'd0, 1'b1, 1'b0, 32'h40, 32'h0, 32'h0);
    @(negedge clk_i);
    dmem_gnt_i = 1'b1;
    @(negedge clk_i);
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'h1234_5678;
    @(negedge clk_i);
    dmem_rvalid_i = 1'b0;
    check("x0_valid", {31'd0, wb_valid_o}, 32'd1);
    check("x0_rw", {31'd0, wb_reg_write_o}, 32'd0);

    // Reset while waiting for load data
    issue(C_LOAD, 3'b010, 5'd4, 1'b1, 1'b0, 32'h80, 32'h0, 32'h0);
    @(negedge clk_i);
    dmem_gnt_i = 1'b1;
    @(negedge clk_i);
    dmem_gnt_i = 1'b0;
    rst_i = 1'b1;
    #1;
    check("arst_req", {31'd0, dmem_req_o}, 32'd0);
    check("arst_valid", {31'd0, wb_valid_o}, 32'd0);
    check("arst_din", wb_rd_din_o, 32'd0);
    check("arst_ready", {31'd0, ex_ready_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'hCAFE_F00D;
    @(negedge clk_i);
    dmem_rvalid_i = 1'b0;
    check("stray_valid", {31'd0, wb_valid_o}, 32'd0);
    req_q.delete();
    issue(C_ALUI, 3'd0, 5'd12, 1'b1, 1'b0, 32'h55AA, 32'h0, 32'h0);
    @(negedge clk_i);
    check("post_rst_valid", {31'd0, wb_valid_o}, 32'd1);
    check("post_rst_din", wb_rd_din_o, 32'h55AA);

    // Randomized traffic
    auto_mem = 1'b1;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 2))
        0:       begin op = C_LOAD;  f3 = 3'($urandom_range(0, 7)); end
        1:       begin op = C_STORE; f3 = st_f3[$urandom_range(0, 5)]; end
        default: begin op = $urandom_range(0, 1) ? C_ALU : C_ALUI; f3 = 3'($urandom_range(0, 7)); end
      endcase
      addr = $urandom;
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      issue(op, f3, rd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            addr, $urandom, $urandom);
    end
    guard = 0;
    while ((wb_q.size() != 0 || req_q.size() != 0) && guard < 200) begin
      @(negedge clk_i);
      guard++;
    end
    check("drain_wb", 32'(wb_q.size()), 32'd0);
    check("drain_req", 32'(req_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
